// File: rtl/phase_timer.sv
// Per-phase dwell timer: counts the current phase's duration down and pulses expire
// when it runs out; sensor/emergency may cut green and left phases short.
module phase_timer #(
   parameter int CNT_W       = 28,
   parameter int T_GREEN     = 250000000,
   parameter int T_YELLOW    = 100000000,
   parameter int T_RED       = 50000000,
   parameter int T_LEFT      = 150000000,
   parameter int T_MIN_GREEN = 100000000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [2:0]       phase,
   input  logic             sensor,
   input  logic             emergency,
   output logic             expire,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_GREEN = CNT_W'(T_GREEN);
   localparam logic [CNT_W-1:0] L_YEL   = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] L_RED   = CNT_W'(T_RED);
   localparam logic [CNT_W-1:0] L_LEFT  = CNT_W'(T_LEFT);
   // Sensor may only act once the minimum green has already elapsed.
   localparam logic [CNT_W-1:0] L_CUT   = CNT_W'(T_GREEN - T_MIN_GREEN);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic [2:0]       r_phase_q;
   logic [2:0]       w_phase_q_nxt;
   logic [CNT_W-1:0] w_reload;
   logic             w_is_green;
   logic             w_is_green_left;
   logic             w_cut;

   // Phase code low bits select the duration class: 00 green, 01 yellow, 10 red, 11 left.
   always_comb begin
      w_reload = L_GREEN - L_ONE;
      case (phase[1:0])
         2'd0:    w_reload = L_GREEN - L_ONE;
         2'd1:    w_reload = L_YEL - L_ONE;
         2'd2:    w_reload = L_RED - L_ONE;
         default: w_reload = L_LEFT - L_ONE;
      endcase
   end

   assign w_is_green      = (r_phase_q[1:0] == 2'd0);
   assign w_is_green_left = (r_phase_q[1] == r_phase_q[0]);
   assign w_cut = (r_remaining != '0) &&
                  ((emergency && w_is_green_left) ||
                   (sensor && w_is_green && (r_remaining < L_CUT)));

   assign expire    = (r_state == S_RUN) && (r_remaining == '0);
   assign remaining = r_remaining;

   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_phase_q_nxt   = r_phase_q;
      case (r_state)
         S_LOAD: begin
            w_state_nxt     = S_RUN;
            w_remaining_nxt = w_reload;
            w_phase_q_nxt   = phase;
         end
         S_RUN, S_HOLD: begin
            if (phase != r_phase_q) begin
               w_state_nxt     = S_RUN;
               w_remaining_nxt = w_reload;
               w_phase_q_nxt   = phase;
            end else if (r_state == S_RUN) begin
               if (r_remaining == '0)
                  w_state_nxt = S_HOLD;
               else if (w_cut)
                  w_remaining_nxt = '0;
               else
                  w_remaining_nxt = r_remaining - L_ONE;
            end
         end
         default: begin
            w_state_nxt     = S_LOAD;
            w_remaining_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_LOAD;
         r_remaining <= '0;
         r_phase_q   <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_phase_q   <= w_phase_q_nxt;
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed scenarios then random stimulus, checked against a
// deadline-based model (absolute cycle at which the current phase is due).
module tb_phase_timer;

   localparam int CNT_W = 8;
   localparam int TG = 10, TY = 3, TR = 2, TL = 5, TMIN = 4;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [2:0]       phase = 3'd0;
   logic             sensor = 1'b0;
   logic             emergency = 1'b0;
   logic             expire;
   logic [CNT_W-1:0] remaining;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a phase is "due" at absolute cycle m_deadline; fired once expire has shown.
   int cyc = 0;
   bit m_started = 0;
   bit m_fired   = 0;
   int m_phase   = 0;
   int m_deadline = 0;

   phase_timer #(
      .CNT_W(CNT_W), .T_GREEN(TG), .T_YELLOW(TY), .T_RED(TR), .T_LEFT(TL),
      .T_MIN_GREEN(TMIN)
   ) dut (
      .clk(clk), .resetn(resetn), .phase(phase), .sensor(sensor),
      .emergency(emergency), .expire(expire), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int dur(input int p);
      case (p % 4)
         0:       return TG;
         1:       return TY;
         2:       return TR;
         default: return TL;
      endcase
   endfunction

   function automatic bit m_exp();
      return m_started && !m_fired && (cyc == m_deadline);
   endfunction

   function automatic int m_rem();
      if (!m_started || m_fired) return 0;
      return m_deadline - cyc;
   endfunction

   // One cycle: check outputs mid-cycle, apply inputs, advance the model to the next cycle.
   task automatic step(input bit rst_n, input int ph, input bit sen, input bit emg);
      int rem;
      @(negedge clk);
      check("expire", int'(expire), int'(m_exp()));
      check("remaining", int'(remaining), m_rem());
      resetn    = rst_n;
      phase     = 3'(ph);
      sensor    = sen;
      emergency = emg;
      rem = m_rem();
      if (!rst_n) begin
         m_started = 0;
         m_fired   = 0;
      end else if (!m_started || ph != m_phase) begin
         m_started  = 1;
         m_fired    = 0;
         m_phase    = ph;
         m_deadline = cyc + dur(ph);
      end else if (m_fired) begin
         // idle until the phase changes
      end else if (m_exp()) begin
         m_fired = 1;
      end else if ((emg && (ph % 4 == 0 || ph % 4 == 3)) ||
                   (sen && ph % 4 == 0 && rem < TG - TMIN)) begin
         m_deadline = cyc + 1;
      end
      cyc++;
   endtask

   task automatic hold(input int ph, input bit sen, input bit emg, input int n);
      for (int i = 0; i < n; i++) step(1'b1, ph, sen, emg);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      // Reset, then a full green count into idle.
      step(1'b0, 0, 0, 0);
      step(1'b0, 0, 0, 0);
      hold(0, 0, 0, 15);
      // Every phase in order, each held past its expiry.
      for (int p = 0; p < 8; p++) hold(p, 0, 0, dur(p) + 2);
      // Sensor from load on green, then emergency on yellow and mid-left.
      step(1'b0, 4, 0, 0);
      hold(4, 1, 0, 9);
      hold(1, 0, 1, 5);
      hold(3, 0, 0, 2);
      hold(3, 0, 1, 3);
      // Phase change landing in the expire cycle.
      hold(2, 0, 0, 1);
      for (int i = 0; i < 6 && !m_exp(); i++) step(1'b1, 2, 0, 0);
      check("exp_before_change", int'(m_exp()), 1);
      hold(7, 0, 0, 7);
      // Reset mid-green, then a fresh count.
      hold(0, 0, 0, 6);
      step(1'b0, 0, 0, 0);
      hold(0, 0, 0, 12);
      // Random traffic.
      begin
         int ph = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) ph = int'($urandom_range(0, 7));
            step(($urandom_range(0, 99) != 0), ph,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
         end
      end
      @(negedge clk);
      check("expire_final", int'(expire), int'(m_exp()));
      check("remaining_final", int'(remaining), m_rem());
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
